// File: rtl/scalar_pkg.sv
// Shared types and helpers for the streaming scalar-product engine.
// Latency: n/a (types, constants and a pure function).
// Backpressure: n/a.
package scalar_pkg;

    typedef enum logic [1:0] {
        ACCUM,
        FLUSH,
        DONE
    } state_e;

    localparam int FLUSH_CYCLES = 2;
    localparam int FLUSH_W      = 2;

    // Needs only the MSBs: carry into the MSB is a^b^s, carry out is the majority of a, b and carry-in.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                     input logic s_msb, input logic is_signed);
        logic c_in;
        logic c_out;
        c_in  = a_msb ^ b_msb ^ s_msb;
        c_out = (a_msb & b_msb) | ((a_msb | b_msb) & ~s_msb);
        return is_signed ? (c_in ^ c_out) : c_out;
    endfunction

endpackage

// File: rtl/dot_lane_tree.sv
// Per-lane multipliers into a product register, then a combinational adder tree to one ACC_W sum.
// Latency: 1 cycle from load to sum/sum_ovf.
// Backpressure: none; products are captured whenever load is high.
module dot_lane_tree
    import scalar_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANES  = 4,
    parameter int ACC_W  = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic                    is_signed,
    input  logic [LANES*DATA_W-1:0] x,
    input  logic [LANES*DATA_W-1:0] y,
    output logic [ACC_W-1:0]        sum,
    output logic                    sum_ovf
);
    localparam int PW = 2 * DATA_W;

    logic [LANES-1:0][PW-1:0] xe;
    logic [LANES-1:0][PW-1:0] ye;
    logic [LANES-1:0][PW-1:0] prod_d;
    logic [LANES-1:0][PW-1:0] prod_q;
    logic                     sgn_d;
    logic                     sgn_q;
    logic [ACC_W-1:0]         node [LANES];
    logic [ACC_W-1:0]         s;
    logic                     ovf;

    // Extending both operands to PW makes one PW-wide multiply correct for either signedness.
    always_comb begin
        prod_d = prod_q;
        sgn_d  = sgn_q;
        for (int i = 0; i < LANES; i++) begin
            xe[i] = {{DATA_W{is_signed & x[i*DATA_W+DATA_W-1]}}, x[i*DATA_W +: DATA_W]};
            ye[i] = {{DATA_W{is_signed & y[i*DATA_W+DATA_W-1]}}, y[i*DATA_W +: DATA_W]};
        end
        if (load) begin
            sgn_d = is_signed;
            for (int i = 0; i < LANES; i++) begin
                prod_d[i] = xe[i] * ye[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            sgn_q  <= 1'b0;
        end else begin
            prod_q <= prod_d;
            sgn_q  <= sgn_d;
        end
    end

    // In-place pairwise reduction: node[i] only reads indices >= i, so one array suffices.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            if (sgn_q) begin
                node[i] = ACC_W'($signed(prod_q[i]));
            end else begin
                node[i] = ACC_W'(prod_q[i]);
            end
        end
        ovf = 1'b0;
        s   = '0;
        for (int w = LANES / 2; w >= 1; w = w / 2) begin
            for (int i = 0; i < w; i++) begin
                s       = node[2*i] + node[2*i+1];
                ovf     = ovf | add_ovf(node[2*i][ACC_W-1], node[2*i+1][ACC_W-1], s[ACC_W-1], sgn_q);
                node[i] = s;
            end
        end
        sum     = node[0];
        sum_ovf = ovf;
    end

endmodule

// File: rtl/scalar_product_stream.sv
// Streaming dot product of two vectors delivered as LANES-wide beats; one vector pair at a time.
// Latency: out_valid rises 3 cycles after the edge accepting the last beat.
// Backpressure: in_ready low from last beat until the result handshake; out_valid holds until out_ready.
module scalar_product_stream
    import scalar_pkg::*;
#(
    parameter  int DATA_W    = 32,
    parameter  int LANES     = 4,
    parameter  int ACC_W     = 64,
    parameter  int MAX_BEATS = 64,
    localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_x,
    input  logic [LANES*DATA_W-1:0] in_y,
    input  logic                    in_last,
    input  logic                    in_signed,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_result,
    output logic [CNT_W-1:0]        out_beats,
    output logic                    out_ovf,
    output logic                    out_len_err
);
    state_e             state_q, state_d;
    logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
    logic               first_q, first_d;
    logic               signed_q, signed_d;
    logic [CNT_W-1:0]   beats_q, beats_d;
    logic               len_err_q, len_err_d;
    logic               p_vld_q, p_vld_d;
    logic               p_first_q, p_first_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_result_q, out_result_d;
    logic [CNT_W-1:0]   out_beats_q, out_beats_d;
    logic               out_ovf_q, out_ovf_d;
    logic               out_len_err_q, out_len_err_d;

    logic               accept;
    logic               mode_now;
    logic               cap_hit;
    logic [ACC_W-1:0]   tree_sum;
    logic               tree_ovf;
    logic [ACC_W-1:0]   acc_sum;

    assign in_ready    = (state_q == ACCUM);
    assign accept      = in_valid && in_ready;
    assign mode_now    = first_q ? in_signed : signed_q;
    assign acc_sum     = acc_q + tree_sum;
    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_beats   = out_beats_q;
    assign out_ovf     = out_ovf_q;
    assign out_len_err = out_len_err_q;

    dot_lane_tree #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .ACC_W  (ACC_W)
    ) u_tree (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .is_signed (mode_now),
        .x         (in_x),
        .y         (in_y),
        .sum       (tree_sum),
        .sum_ovf   (tree_ovf)
    );

    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        first_d       = first_q;
        signed_d      = signed_q;
        beats_d       = beats_q;
        len_err_d     = len_err_q;
        p_vld_d       = accept;
        p_first_d     = accept && first_q;
        acc_d         = acc_q;
        ovf_d         = ovf_q;
        out_valid_d   = out_valid_q;
        out_result_d  = out_result_q;
        out_beats_d   = out_beats_q;
        out_ovf_d     = out_ovf_q;
        out_len_err_d = out_len_err_q;
        cap_hit       = 1'b0;

        // Stage 2: the first beat of a vector overwrites rather than accumulates.
        if (p_vld_q) begin
            if (p_first_q) begin
                acc_d = tree_sum;
                ovf_d = tree_ovf;
            end else begin
                acc_d = acc_sum;
                ovf_d = ovf_q | tree_ovf |
                        add_ovf(acc_q[ACC_W-1], tree_sum[ACC_W-1], acc_sum[ACC_W-1], signed_q);
            end
        end

        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    beats_d   = first_q ? CNT_W'(1) : beats_q + CNT_W'(1);
                    cap_hit   = (beats_d == CNT_W'(MAX_BEATS));
                    len_err_d = cap_hit && !in_last;
                    signed_d  = mode_now;
                    first_d   = 1'b0;
                    if (in_last || cap_hit) begin
                        state_d     = FLUSH;
                        flush_cnt_d = '0;
                    end
                end
            end
            FLUSH: begin
                if (flush_cnt_q == FLUSH_W'(FLUSH_CYCLES - 1)) begin
                    state_d     = DONE;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
                end
            end
            DONE: begin
                // Result registers load on the first DONE cycle so out_* are stable while out_valid is high.
                if (!out_valid_q) begin
                    out_valid_d   = 1'b1;
                    out_result_d  = acc_q;
                    out_beats_d   = beats_q;
                    out_ovf_d     = ovf_q;
                    out_len_err_d = len_err_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACCUM;
                    first_d     = 1'b1;
                end
            end
            default: begin
                state_d = ACCUM;
                first_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ACCUM;
            flush_cnt_q   <= '0;
            first_q       <= 1'b1;
            signed_q      <= 1'b0;
            beats_q       <= '0;
            len_err_q     <= 1'b0;
            p_vld_q       <= 1'b0;
            p_first_q     <= 1'b0;
            acc_q         <= '0;
            ovf_q         <= 1'b0;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_beats_q   <= '0;
            out_ovf_q     <= 1'b0;
            out_len_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            first_q       <= first_d;
            signed_q      <= signed_d;
            beats_q       <= beats_d;
            len_err_q     <= len_err_d;
            p_vld_q       <= p_vld_d;
            p_first_q     <= p_first_d;
            acc_q         <= acc_d;
            ovf_q         <= ovf_d;
            out_valid_q   <= out_valid_d;
            out_result_q  <= out_result_d;
            out_beats_q   <= out_beats_d;
            out_ovf_q     <= out_ovf_d;
            out_len_err_q <= out_len_err_d;
        end
    end

endmodule

// File: tb/tb_scalar_product_stream.sv
// Directed bench for scalar_product_stream (LANES=4, DATA_W=32, ACC_W=64, MAX_BEATS=4).
module tb_scalar_product_stream;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         in_signed = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_x = '0;
    logic [127:0] in_y = '0;
    logic         in_ready;
    logic         out_valid;
    logic         out_ovf;
    logic         out_len_err;
    logic [63:0]  out_result;
    logic [2:0]   out_beats;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    scalar_product_stream #(
        .DATA_W    (32),
        .LANES     (4),
        .ACC_W     (64),
        .MAX_BEATS (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_last     (in_last),
        .in_signed   (in_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_beats   (out_beats),
        .out_ovf     (out_ovf),
        .out_len_err (out_len_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] lanes(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    task automatic send(input logic [127:0] x, input logic [127:0] y,
                        input logic last, input logic sgn);
        int n;
        in_x      = x;
        in_y      = y;
        in_last   = last;
        in_signed = sgn;
        in_valid  = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            step();
            n++;
        end
        if (!in_ready) chk("accept_timeout", {63'b0, in_ready}, 64'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, {63'b0, out_valid}, 64'd1);
    endtask

    task automatic check_res(input string tag, input logic [63:0] res, input logic [2:0] beats,
                             input logic ovf, input logic lerr);
        chk({tag, "_result"}, out_result, res);
        chk({tag, "_beats"}, {61'b0, out_beats}, {61'b0, beats});
        chk({tag, "_ovf"}, {63'b0, out_ovf}, {63'b0, ovf});
        chk({tag, "_len_err"}, {63'b0, out_len_err}, {63'b0, lerr});
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_hs_in_ready"}, {63'b0, in_ready}, 64'd1);
        chk({tag, "_hs_out_valid"}, {63'b0, out_valid}, 64'd0);
    endtask

    initial begin
        logic [127:0] ones;
        ones = lanes(1, 1, 1, 1);

        // Reset values
        #1;
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check_res("rst", 64'd0, 3'd0, 1'b0, 1'b0);
        step();
        step();
        rst_n = 1'b1;

        // Unsigned 2 beats, latency, early out_ready has no effect
        out_ready = 1'b1;
        send(lanes(1, 2, 3, 4), ones, 1'b0, 1'b0);
        send(lanes(5, 6, 7, 8), ones, 1'b1, 1'b0);
        chk("t1_busy", {63'b0, in_ready}, 64'd0);
        step();
        chk("t1_lat1", {63'b0, out_valid}, 64'd0);
        step();
        chk("t1_lat2", {63'b0, out_valid}, 64'd0);
        step();
        chk("t1_lat3", {63'b0, out_valid}, 64'd1);
        check_res("t1", 64'd36, 3'd2, 1'b0, 1'b0);
        step();
        out_ready = 1'b0;
        chk("t1_after_valid", {63'b0, out_valid}, 64'd0);
        chk("t1_after_ready", {63'b0, in_ready}, 64'd1);

        // Signed single beat
        send(lanes(-1, 2, -3, 4), lanes(5, 5, 5, 5), 1'b1, 1'b1);
        wait_out("t2s");
        check_res("t2s", 64'd10, 3'd1, 1'b0, 1'b0);
        handshake("t2s");

        // Same data unsigned
        send(lanes(-1, 2, -3, 4), lanes(5, 5, 5, 5), 1'b1, 1'b0);
        wait_out("t2u");
        check_res("t2u", 64'h0000_000A_0000_000A, 3'd1, 1'b0, 1'b0);
        handshake("t2u");

        // Unsigned overflow over 2 beats
        send({4{32'hFFFF_FFFF}}, {4{32'hFFFF_FFFF}}, 1'b0, 1'b0);
        send({4{32'hFFFF_FFFF}}, {4{32'hFFFF_FFFF}}, 1'b1, 1'b0);
        wait_out("t3u");
        check_res("t3u", 64'hFFFF_FFF0_0000_0008, 3'd2, 1'b1, 1'b0);
        handshake("t3u");

        // Signed overflow inside the lane tree: 4 x 2^62 wraps to 0
        send({4{32'h8000_0000}}, {4{32'h8000_0000}}, 1'b1, 1'b1);
        wait_out("t3s");
        check_res("t3s", 64'd0, 3'd1, 1'b1, 1'b0);
        handshake("t3s");

        // Exactly MAX_BEATS with in_last: no length error
        for (int k = 1; k <= 4; k++) send(ones, ones, (k == 4), 1'b0);
        wait_out("t4a");
        check_res("t4a", 64'd16, 3'd4, 1'b0, 1'b0);
        handshake("t4a");

        // Truncation: 4 beats without in_last, then beats 5-6 form a new vector
        for (int k = 1; k <= 4; k++) send(ones, lanes(k, k, k, k), 1'b0, 1'b0);
        wait_out("t4b");
        check_res("t4b", 64'd40, 3'd4, 1'b0, 1'b1);
        handshake("t4b");
        send(ones, lanes(5, 5, 5, 5), 1'b0, 1'b0);
        send(ones, lanes(6, 6, 6, 6), 1'b1, 1'b0);
        wait_out("t4c");
        check_res("t4c", 64'd44, 3'd2, 1'b0, 1'b0);
        handshake("t4c");

        // Backpressure; in_signed on beat 2 must be ignored (-4 + -2)
        send(lanes(-1, -1, -1, -1), ones, 1'b0, 1'b1);
        send(lanes(-1, 0, 0, 0), lanes(2, 0, 0, 0), 1'b1, 1'b0);
        wait_out("t5");
        check_res("t5", 64'hFFFF_FFFF_FFFF_FFFA, 3'd2, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            chk("t5_hold_valid", {63'b0, out_valid}, 64'd1);
            chk("t5_hold_result", out_result, 64'hFFFF_FFFF_FFFF_FFFA);
            chk("t5_hold_in_ready", {63'b0, in_ready}, 64'd0);
            step();
        end
        handshake("t5");

        // Reset mid-vector
        send(ones, ones, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", {63'b0, out_valid}, 64'd0);
        chk("t6_rst_in_ready", {63'b0, in_ready}, 64'd1);
        check_res("t6_rst", 64'd0, 3'd0, 1'b0, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        send(lanes(1, 2, 3, 4), ones, 1'b1, 1'b0);
        wait_out("t6");
        check_res("t6", 64'd10, 3'd1, 1'b0, 1'b0);
        handshake("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/scalar_product_stream.md
# scalar_product_stream

Parametrised streaming dot-product engine: accepts two vectors as a sequence of multi-lane beats over a valid/ready handshake and returns their scalar product, with signed/unsigned mode and overflow/length status. Successor to the purely combinational scalar-product block. It sits between the operand memory readers and the result FIFO in the algebra datapath. It processes one vector pair at a time, with a 2-stage multiply/accumulate pipeline.

## Interface
- `DATA_W`, 32: bit width of one element of X and Y.
- `LANES`, 4: elements consumed per beat (power of 2, ≥1).
- `ACC_W`, 64: accumulator and result width (≥ 2*DATA_W).
- `MAX_BEATS`, 64: maximum beats per vector; `CNT_W = $clog2(MAX_BEATS+1)`.

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `in_valid` input 1: beat valid.
- `in_ready` output 1: engine can accept a beat.
- `in_x` input LANES*DATA_W: lane i at `[i*DATA_W +: DATA_W]`.
- `in_y` input LANES*DATA_W: same packing as `in_x`.
- `in_last` input 1: final beat of the vector.
- `in_signed` input 1: operand interpretation; sampled on the first beat of a vector only.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts the result.
- `out_result` output ACC_W: dot product modulo 2^ACC_W.
- `out_beats` output CNT_W: number of beats accumulated.
- `out_ovf` output 1: sticky accumulator overflow for this vector.
- `out_len_err` output 1: vector truncated at MAX_BEATS.

## Operation
- A beat is accepted when `in_valid && in_ready`. `in_ready` = (state == ACCUM).
- Products per lane are computed at DATA_W×DATA_W → 2*DATA_W, signed or unsigned per the sampled mode. They are sign- or zero-extended to ACC_W, summed across lanes and added to the accumulator.
- Arithmetic wraps modulo 2^ACC_W.
- `out_ovf` is set sticky if any lane-sum or accumulate step overflows the ACC_W range:
  - signed mode: carry-in ≠ carry-out of the MSB;
  - unsigned mode: carry-out.
- States:
  - ACCUM: accept beats. The first beat of a vector clears the accumulator, beat counter and flags, and latches `in_signed`. On acceptance with `in_last`, or when the beat count reaches MAX_BEATS, go to FLUSH. Reaching MAX_BEATS without `in_last` sets `out_len_err`.
  - FLUSH: 2 cycles while the pipeline drains; `in_ready`=0. Then go to DONE.
  - DONE: `out_valid`=1 and outputs are stable. When `out_ready`=1, return to ACCUM with the next-vector flag set.
- After truncation, further beats up to and including the one with `in_last` are the caller's responsibility. The engine treats them as a new vector.
- Reset mid-vector aborts all work. No result is emitted for the aborted vector.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_result`=0, `out_beats`=0, `out_ovf`=0, `out_len_err`=0, state ACCUM.
- Throughput: 1 beat/cycle within a vector.
- Pipeline: stage 1 registers the lane products; stage 2 registers the accumulator.
- Latency: `out_valid` rises 3 cycles after the clock edge that accepts the last beat.
- `out_valid` holds until `out_ready`. `in_ready` rises the cycle after the result handshake, giving 4 cycles of idle per vector minimum.
- `out_ready` asserted while `out_valid`=0 has no effect.
- `in_signed` on non-first beats is ignored.

## Structure
- Package `scalar_pkg` contains:
  - the state enum (ACCUM, FLUSH, DONE);
  - the FLUSH_CYCLES=2 constant;
  - a helper function for the signed/unsigned overflow check.
- Sub-module `dot_lane_tree`: LANES multipliers, product register, and a combinational adder tree to one ACC_W sum with an overflow flag. The top level holds the FSM, counter, accumulator and output registers.

## Test plan
- Unsigned, LANES=4, 2 beats. X={1,2,3,4},{5,6,7,8}; Y all 1, `in_last` on beat 2 → `out_result`=36, `out_beats`=2, `out_ovf`=0, `out_valid` 3 cycles after the last beat.
- Signed, 1 beat. X={-1,2,-3,4}, Y={5,5,5,5} → `out_result`=10. The same data in unsigned mode → (2^32−1)·5 + 10 − 3·... as wrapped unsigned; checked against a model.
- Overflow, ACC_W=64, unsigned. X=Y=0xFFFF_FFFF in all lanes for 2 beats → wrapped result matches the model, `out_ovf`=1.
- Length. MAX_BEATS=4, 6 beats without `in_last` → result after 4 beats, `out_len_err`=1, `out_beats`=4. Beats 5–6 start a new vector.
- Backpressure. Hold `out_ready`=0 for 10 cycles → `out_valid` and `out_result` stay stable and `in_ready`=0 throughout. The next vector starts the cycle after the handshake.
- Reset. Assert `rst_n`=0 after beat 1 of 3 → all outputs reset immediately. A following 1-beat vector returns a clean result.
